axi_tdd_ng_sync_gen_mc: RTL and testbench
=========================================

Name: axi_tdd_ng_sync_gen_mc

Overview:
Next-generation TDD frame-sync generator with multiple external sync inputs, each with optional CDC and selectable edge polarity. It adds an arm-on-external-event mode, an internal periodic generator with start offset and burst count, and programmable output pulse width. It also reports state, a pulse count and an overrun flag. It sits between the TDD register map (asy_* quasi-static config) and the TDD counter core, driving its frame-start sync.

Parameters:
NUM_EXT_SYNC, 2, number of external sync inputs (1..8)
EXT_CDC_MASK, 0, bit i=1 inserts 2-flop CDC ahead of sync_in[i] edge detector
SYNC_INTERNAL, 1, 0 removes internal period generator (internal trigger tied 0)
SYNC_COUNT_WIDTH, 32, width of period/offset counters and tdd_sync_count
BURST_WIDTH, 16, width of burst count
PW_WIDTH, 8, width of output pulse-width field

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
sync_in  in  NUM_EXT_SYNC  external sync inputs
sync_out  out  1  registered, stretched sync pulse
tdd_enable  in  1  block enable; 0 forces IDLE
tdd_sync_ext_mask  in  NUM_EXT_SYNC  per-input enable for external sync
tdd_sync_ext_edge  in  2  00 none, 01 rising, 10 falling, 11 both
tdd_sync_int  in  1  enable internal periodic triggers
tdd_sync_soft  in  1  single-cycle software sync request
tdd_sync_arm_ext  in  1  1: wait for external/soft event before internal generator starts
asy_tdd_sync_period  in  SYNC_COUNT_WIDTH  internal period in cycles; 0 = no internal pulses
asy_tdd_sync_offset  in  SYNC_COUNT_WIDTH  cycles from RUNNING entry to first internal pulse
asy_tdd_sync_burst  in  BURST_WIDTH  internal pulses before DONE; 0 = unlimited
asy_tdd_sync_pulse_width  in  PW_WIDTH  sync_out high time in cycles; 0 treated as 1
tdd_sync_state  out  2  encoded FSM state
tdd_sync_count  out  SYNC_COUNT_WIDTH  triggers emitted since enable, saturating
tdd_sync_overrun  out  1  sticky: trigger arrived while sync_out still stretching

Behaviour:
- Reset: sync_out=0, state=IDLE, tdd_sync_count=0, tdd_sync_overrun=0, all counters/CDC/edge flops 0, captured config 0.
- FSM states are IDLE(00), ARMED(01), RUNNING(10), DONE(11).
- IDLE: captures all asy_* inputs every cycle while in IDLE. Captured values are frozen once IDLE is left. On tdd_enable=1 it goes to ARMED if tdd_sync_arm_ext=1, else RUNNING. Entering either clears count and overrun.
- ARMED: waits for a trigger event (qualified external edge or soft), then goes to RUNNING. That trigger is also emitted on sync_out.
- RUNNING: the offset counter runs first. The internal trigger fires when the offset elapses, then every period cycles. After burst internal triggers (burst≠0) it goes to DONE.
- DONE: internal generator stopped. External and soft triggers are still forwarded.
- tdd_enable=0 in any state: IDLE next edge. Counters clear and sync_out drops the same edge, even mid-stretch.
- Edge detect per input: stage s0 samples sync_in (behind 2 CDC flops if EXT_CDC_MASK[i]). Edge is computed from s0 vs s1. An input qualifies only if tdd_sync_ext_mask[i]=1 and tdd_sync_ext_edge matches.
- Latency: sync_in first sampled at edge k → sync_out high from edge k+2 (no CDC) or k+4 (CDC).
- Internal latency, with edge 0 the first edge sampling tdd_enable=1 and arm_ext=0: first sync_out rises at edge offset+2, then every period cycles.
- Period=1 gives a trigger every cycle.
- Internal triggers are gated by tdd_sync_int and SYNC_INTERNAL.
- Simultaneous triggers (any mix of sources) in one cycle count as one trigger: count +1, one pulse.
- Stretch: a trigger loads the width counter with pulse_width. sync_out is high while the counter is nonzero. A trigger while the counter is >1 reloads it (extends the pulse) and sets tdd_sync_overrun.
- tdd_sync_count saturates at all-ones. The burst counter counts internal triggers only.

Decomposition:
- Package axi_tdd_ng_pkg holds the state enum (IDLE/ARMED/RUNNING/DONE, 2-bit) and the edge-select encoding constants.
- Sub-module axi_tdd_ng_sync_edge_det (params CDC_EN, output edge pulse with edge select) is instantiated NUM_EXT_SYNC times via generate.

Test Plan:
- Case 1, internal periodic: period=4, offset=0, burst=0, pw=1, int=1; enable at edge 0 → sync_out high at edges 2,6,10,…; count increments each.
- Case 2, burst: period=3, offset=5, burst=2 → pulses at edges 7,10; state=DONE after 10; no further pulses; count=2.
- Case 3, armed start: arm_ext=1, ext_mask=01, edge=01, period=8, offset=0. sync_in[0] rises at edge 20 (no CDC) → sync_out at edge 22, state RUNNING, internal pulses follow; prior to edge 20 state=ARMED.
- Case 4, CDC and edges: EXT_CDC_MASK=10, edge=11. Toggling sync_in[1] high at edge 5 gives sync_out at 9; low at edge 15 gives sync_out at 19. Masked input produces nothing.
- Case 5, overlap: pw=4; soft at edge 10 and internal trigger same cycle → one pulse, count+1. A second soft at edge 12 → pulse extended to 4 cycles from the retrigger, overrun=1.
- Case 6, disable/reset mid-pulse: enable=0 during stretch → sync_out=0, state=IDLE next edge. reset=1 mid-run → all outputs 0 next edge.

Source files
------------

// File: rtl/axi_tdd_ng_pkg.sv
// Shared types for the next-gen TDD frame-sync generator.
// Holds the FSM state encoding and the external edge-select codes.
package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_RUNNING = 2'b10,
    ST_DONE    = 2'b11
  } sync_state_e;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

endpackage

// File: rtl/axi_tdd_ng_sync_gen_mc_edge.sv
// Per-input edge detector with optional 2-flop synchronizer ahead of it.
// The edge is formed from s0 vs s1, so the pulse is combinational after s0.
module axi_tdd_ng_sync_edge_det
  import axi_tdd_ng_pkg::*;
#(
  parameter bit CDC_EN = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_in,
  input  logic [1:0] edge_sel,
  output logic       edge_pulse
);

  logic samp;
  logic s0;
  logic s1;
  logic rise_en;
  logic fall_en;

  generate
    if (CDC_EN) begin : g_cdc
      logic [1:0] meta;
      always_ff @(posedge clk) begin
        if (reset) meta <= '0;
        else       meta <= {meta[0], sync_in};
      end
      assign samp = meta[1];
    end else begin : g_nocdc
      assign samp = sync_in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= samp;
      s1 <= s0;
    end
  end

  assign rise_en    = (edge_sel == EDGE_RISE) || (edge_sel == EDGE_BOTH);
  assign fall_en    = (edge_sel == EDGE_FALL) || (edge_sel == EDGE_BOTH);
  assign edge_pulse = (rise_en && s0 && !s1) || (fall_en && !s0 && s1);

endmodule

// File: rtl/axi_tdd_ng_sync_gen_mc.sv
// TDD frame-sync generator: external/soft/internal triggers merged into one
// stretched pulse. state | meaning
//   IDLE    | config tracks asy_* inputs, no triggers accepted
//   ARMED   | waiting for external or soft event to start
//   RUNNING | offset then periodic internal triggers, plus ext/soft
//   DONE    | burst exhausted, only ext/soft forwarded
module axi_tdd_ng_sync_gen_mc
  import axi_tdd_ng_pkg::*;
#(
  parameter int             NUM_EXT_SYNC     = 2,
  parameter logic [7:0]     EXT_CDC_MASK     = 8'h00,
  parameter int             SYNC_INTERNAL    = 1,
  parameter int             SYNC_COUNT_WIDTH = 32,
  parameter int             BURST_WIDTH      = 16,
  parameter int             PW_WIDTH         = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_EXT_SYNC-1:0]     sync_in,
  output logic                        sync_out,
  input  logic                        tdd_enable,
  input  logic [NUM_EXT_SYNC-1:0]     tdd_sync_ext_mask,
  input  logic [1:0]                  tdd_sync_ext_edge,
  input  logic                        tdd_sync_int,
  input  logic                        tdd_sync_soft,
  input  logic                        tdd_sync_arm_ext,
  input  logic [SYNC_COUNT_WIDTH-1:0] asy_tdd_sync_period,
  input  logic [SYNC_COUNT_WIDTH-1:0] asy_tdd_sync_offset,
  input  logic [BURST_WIDTH-1:0]      asy_tdd_sync_burst,
  input  logic [PW_WIDTH-1:0]         asy_tdd_sync_pulse_width,
  output logic [1:0]                  tdd_sync_state,
  output logic [SYNC_COUNT_WIDTH-1:0] tdd_sync_count,
  output logic                        tdd_sync_overrun
);

  sync_state_e state, state_nxt;

  logic [SYNC_COUNT_WIDTH-1:0] cfg_period;
  logic [SYNC_COUNT_WIDTH-1:0] cfg_offset;
  logic [BURST_WIDTH-1:0]      cfg_burst;
  logic [PW_WIDTH-1:0]         cfg_pw;
  logic [PW_WIDTH-1:0]         pw_eff;

  logic [SYNC_COUNT_WIDTH-1:0] tmr;
  logic [BURST_WIDTH-1:0]      burst_cnt;
  logic [PW_WIDTH-1:0]         width_cnt;
  logic [NUM_EXT_SYNC-1:0]     edge_vec;

  logic ext_fire;
  logic int_fire;
  logic last_burst;
  logic trig;
  logic trig_q;

  for (genvar i = 0; i < NUM_EXT_SYNC; i++) begin : g_ext
    axi_tdd_ng_sync_edge_det #(
      .CDC_EN (EXT_CDC_MASK[i])
    ) u_edge_det (
      .clk        (clk),
      .reset      (reset),
      .sync_in    (sync_in[i]),
      .edge_sel   (tdd_sync_ext_edge),
      .edge_pulse (edge_vec[i])
    );
  end

  assign ext_fire   = |(edge_vec & tdd_sync_ext_mask);
  assign int_fire   = (SYNC_INTERNAL != 0) && tdd_sync_int && (state == ST_RUNNING) &&
                      (cfg_period != '0) && (tmr == '0);
  assign last_burst = int_fire && (cfg_burst != '0) &&
                      (burst_cnt == cfg_burst - BURST_WIDTH'(1));
  assign pw_eff     = (cfg_pw == '0) ? PW_WIDTH'(1) : cfg_pw;

  always_comb begin
    trig = 1'b0;
    if (tdd_enable) begin
      unique case (state)
        ST_ARMED, ST_DONE: trig = ext_fire || tdd_sync_soft;
        ST_RUNNING:        trig = ext_fire || tdd_sync_soft || int_fire;
        default:           trig = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!tdd_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    state_nxt = tdd_sync_arm_ext ? ST_ARMED : ST_RUNNING;
        ST_ARMED:   if (ext_fire || tdd_sync_soft) state_nxt = ST_RUNNING;
        ST_RUNNING: if (last_burst) state_nxt = ST_DONE;
        default:    state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_period <= '0;
      cfg_offset <= '0;
      cfg_burst  <= '0;
      cfg_pw     <= '0;
    end else if (state == ST_IDLE) begin
      cfg_period <= asy_tdd_sync_period;
      cfg_offset <= asy_tdd_sync_offset;
      cfg_burst  <= asy_tdd_sync_burst;
      cfg_pw     <= asy_tdd_sync_pulse_width;
    end
  end

  // Timer is preloaded with the offset until RUNNING, then reloads with period-1.
  always_ff @(posedge clk) begin
    if (reset || !tdd_enable) begin
      tmr       <= '0;
      burst_cnt <= '0;
    end else if (state == ST_IDLE) begin
      tmr       <= asy_tdd_sync_offset;
      burst_cnt <= '0;
    end else if (state == ST_ARMED) begin
      tmr       <= cfg_offset;
      burst_cnt <= '0;
    end else if (state == ST_RUNNING) begin
      if (int_fire) begin
        tmr       <= cfg_period - SYNC_COUNT_WIDTH'(1);
        burst_cnt <= burst_cnt + BURST_WIDTH'(1);
      end else if (tmr != '0) begin
        tmr <= tmr - SYNC_COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q           <= 1'b0;
      width_cnt        <= '0;
      sync_out         <= 1'b0;
      tdd_sync_count   <= '0;
      tdd_sync_overrun <= 1'b0;
    end else if (!tdd_enable) begin
      trig_q    <= 1'b0;
      width_cnt <= '0;
      sync_out  <= 1'b0;
    end else begin
      trig_q <= trig;
      if (trig_q) begin
        width_cnt <= pw_eff;
        if (width_cnt > PW_WIDTH'(1)) tdd_sync_overrun <= 1'b1;
      end else if (width_cnt != '0) begin
        width_cnt <= width_cnt - PW_WIDTH'(1);
      end
      sync_out <= trig_q || (width_cnt > PW_WIDTH'(1));
      // Leaving IDLE starts a fresh count/overrun window.
      if (state == ST_IDLE) begin
        tdd_sync_count   <= '0;
        tdd_sync_overrun <= 1'b0;
      end else if (trig && (tdd_sync_count != '1)) begin
        tdd_sync_count <= tdd_sync_count + SYNC_COUNT_WIDTH'(1);
      end
    end
  end

  assign tdd_sync_state = state;

endmodule

// File: tb/tb_axi_tdd_ng_sync_gen_mc.sv
// Directed bench for axi_tdd_ng_sync_gen_mc; input 1 goes through the CDC path.
// Edge e below means the e-th posedge after tdd_enable is first sampled high.
module tb_axi_tdd_ng_sync_gen_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sync_in;
  logic        sync_out;
  logic        tdd_enable;
  logic [1:0]  tdd_sync_ext_mask;
  logic [1:0]  tdd_sync_ext_edge;
  logic        tdd_sync_int;
  logic        tdd_sync_soft;
  logic        tdd_sync_arm_ext;
  logic [31:0] period;
  logic [31:0] offset;
  logic [15:0] burst;
  logic [7:0]  pw;
  logic [1:0]  tdd_sync_state;
  logic [31:0] tdd_sync_count;
  logic        tdd_sync_overrun;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] rec;
  logic [1:0]  st_a, st_b;

  always #5 clk = ~clk;

  axi_tdd_ng_sync_gen_mc #(
    .NUM_EXT_SYNC     (2),
    .EXT_CDC_MASK     (8'b0000_0010),
    .SYNC_INTERNAL    (1),
    .SYNC_COUNT_WIDTH (32),
    .BURST_WIDTH      (16),
    .PW_WIDTH         (8)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .sync_in                  (sync_in),
    .sync_out                 (sync_out),
    .tdd_enable               (tdd_enable),
    .tdd_sync_ext_mask        (tdd_sync_ext_mask),
    .tdd_sync_ext_edge        (tdd_sync_ext_edge),
    .tdd_sync_int             (tdd_sync_int),
    .tdd_sync_soft            (tdd_sync_soft),
    .tdd_sync_arm_ext         (tdd_sync_arm_ext),
    .asy_tdd_sync_period      (period),
    .asy_tdd_sync_offset      (offset),
    .asy_tdd_sync_burst       (burst),
    .asy_tdd_sync_pulse_width (pw),
    .tdd_sync_state           (tdd_sync_state),
    .tdd_sync_count           (tdd_sync_count),
    .tdd_sync_overrun         (tdd_sync_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stop_run();
    tdd_enable = 1'b0;
    tdd_sync_soft = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; sync_in = '0; tdd_enable = 1'b0;
    tdd_sync_ext_mask = '0; tdd_sync_ext_edge = 2'b00;
    tdd_sync_int = 1'b0; tdd_sync_soft = 1'b0; tdd_sync_arm_ext = 1'b0;
    period = '0; offset = '0; burst = '0; pw = '0;
    repeat (3) tick();
    chk("reset_sync_out", 64'(sync_out), 64'd0);
    chk("reset_state", 64'(tdd_sync_state), 64'd0);
    chk("reset_count", 64'(tdd_sync_count), 64'd0);
    chk("reset_overrun", 64'(tdd_sync_overrun), 64'd0);
    reset = 1'b0;
    tick();

    // Case 1: periodic, period 4, offset 0 -> pulses at edges 2,6,10
    period = 4; offset = 0; burst = 0; pw = 1; tdd_sync_int = 1'b1;
    tdd_enable = 1'b1;
    rec = '0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      rec[e] = sync_out;
    end
    chk("c1_pulses", rec, 64'h444);
    chk("c1_count", 64'(tdd_sync_count), 64'd3);
    chk("c1_state", 64'(tdd_sync_state), 64'd2);
    stop_run();

    // Case 2: burst of 2, period 3, offset 5 -> pulses at 7,10 then DONE
    period = 3; offset = 5; burst = 2; pw = 1;
    tdd_enable = 1'b1;
    rec = '0; st_a = '0; st_b = '0;
    for (int e = 0; e <= 15; e++) begin
      tick();
      rec[e] = sync_out;
      if (e == 8)  st_a = tdd_sync_state;
      if (e == 10) st_b = tdd_sync_state;
    end
    chk("c2_pulses", rec, 64'h480);
    chk("c2_state_e8", 64'(st_a), 64'd2);
    chk("c2_state_e10", 64'(st_b), 64'd3);
    chk("c2_count", 64'(tdd_sync_count), 64'd2);
    stop_run();

    // Case 3: armed start on rising sync_in[0] sampled at edge 20
    tdd_sync_arm_ext = 1'b1; tdd_sync_ext_mask = 2'b01; tdd_sync_ext_edge = 2'b01;
    period = 8; offset = 0; burst = 0; pw = 1;
    tdd_enable = 1'b1;
    rec = '0; st_a = '0; st_b = '0;
    for (int e = 0; e <= 40; e++) begin
      tick();
      rec[e] = sync_out;
      if (e == 19) begin st_a = tdd_sync_state; sync_in[0] = 1'b1; end
      if (e == 21) st_b = tdd_sync_state;
    end
    chk("c3_pulses", rec, (64'd1 << 22) | (64'd1 << 23) | (64'd1 << 31) | (64'd1 << 39));
    chk("c3_state_armed", 64'(st_a), 64'd1);
    chk("c3_state_running", 64'(st_b), 64'd2);
    chk("c3_count", 64'(tdd_sync_count), 64'd4);
    chk("c3_overrun", 64'(tdd_sync_overrun), 64'd0);
    stop_run();

    // Case 4: CDC input 1, both edges; input 0 toggles but is masked
    tdd_sync_arm_ext = 1'b0; tdd_sync_int = 1'b0; tdd_sync_ext_mask = 2'b10;
    tdd_sync_ext_edge = 2'b11; period = 0; pw = 1;
    tdd_enable = 1'b1;
    rec = '0;
    for (int e = 0; e <= 24; e++) begin
      tick();
      rec[e] = sync_out;
      if (e == 2)  sync_in[0] = 1'b0;
      if (e == 4)  sync_in[1] = 1'b1;
      if (e == 11) sync_in[0] = 1'b1;
      if (e == 14) sync_in[1] = 1'b0;
    end
    chk("c4_pulses", rec, (64'd1 << 9) | (64'd1 << 19));
    chk("c4_count", 64'(tdd_sync_count), 64'd2);
    stop_run();

    // Case 5: soft coincident with internal at edge 10, retrigger at 12
    tdd_sync_ext_mask = 2'b00; tdd_sync_int = 1'b1;
    period = 10; offset = 9; burst = 0; pw = 4;
    tdd_enable = 1'b1;
    rec = '0; st_a = '0; st_b = '0;
    for (int e = 0; e <= 19; e++) begin
      tick();
      rec[e] = sync_out;
      if (e == 12) st_a = {1'b0, tdd_sync_overrun};
      if (e == 13) st_b = {1'b0, tdd_sync_overrun};
      tdd_sync_soft = (e == 9) || (e == 11);
    end
    chk("c5_pulses", rec, 64'h1F800);
    chk("c5_count", 64'(tdd_sync_count), 64'd2);
    chk("c5_overrun_e12", 64'(st_a), 64'd0);
    chk("c5_overrun_e13", 64'(st_b), 64'd1);

    // Case 6a: disable mid-stretch (internal pulse 21..24)
    tick(); tick(); tick();
    chk("c6_sync_before_disable", 64'(sync_out), 64'd1);
    tdd_enable = 1'b0;
    tick();
    chk("c6_disable_sync", 64'(sync_out), 64'd0);
    chk("c6_disable_state", 64'(tdd_sync_state), 64'd0);
    tick();

    // Case 6b: synchronous reset mid-run with overrun set
    tdd_enable = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      tdd_sync_soft = (e == 10);
    end
    chk("c6_pre_reset_sync", 64'(sync_out), 64'd1);
    chk("c6_pre_reset_count", 64'(tdd_sync_count), 64'd2);
    chk("c6_pre_reset_overrun", 64'(tdd_sync_overrun), 64'd1);
    reset = 1'b1;
    tick();
    chk("c6_reset_sync", 64'(sync_out), 64'd0);
    chk("c6_reset_state", 64'(tdd_sync_state), 64'd0);
    chk("c6_reset_count", 64'(tdd_sync_count), 64'd0);
    chk("c6_reset_overrun", 64'(tdd_sync_overrun), 64'd0);
    tdd_enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Boundary: period 1, pulse width 0 (treated as 1) -> high from edge 2 on
    period = 1; offset = 0; pw = 0;
    tdd_enable = 1'b1;
    rec = '0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      rec[e] = sync_out;
    end
    chk("p1_pulses", rec, 64'hFC);
    chk("p1_count", 64'(tdd_sync_count), 64'd7);
    chk("p1_overrun", 64'(tdd_sync_overrun), 64'd0);
    stop_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
